noc_local_inject_queue: RTL and testbench

//  Tile-side injection stage that feeds one router_mesh local port (port index 4).
//  - Accepts tile send requests and forms 64-bit flits with the dest header (flit[15:8]=row, flit[7:0]=col).
//  - Drops requests whose destination lies outside the mesh, and counts them.
//  - Buffers flits in a FIFO and presents them on a valid/ready link to the router.
//  - Reports occupancy, a high-watermark and a stall alarm for long-tail backpressure.

---
 rtl/noc_local_inject_queue_if.sv | 25 ++
 rtl/noc_local_inject_queue.sv | 119 +++++++++++
 tb/tb_noc_local_inject_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/noc_local_inject_queue_if.sv
// Tile request channel plus router local-port flit link for the injection queue.
interface noc_local_inject_queue_if #(
  parameter int unsigned FLIT_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_dest_row;
  logic [7:0]        req_dest_col;
  logic [FLIT_W-17:0] req_payload;
  logic [FLIT_W-1:0] flit_out;
  logic              valid_out;
  logic              ready_in;

  // Tile/router side: issues requests and consumes flits.
  modport master (
    output req_valid, req_dest_row, req_dest_col, req_payload, ready_in,
    input  req_ready, flit_out, valid_out
  );

  // Injection queue side.
  modport slave (
    input  req_valid, req_dest_row, req_dest_col, req_payload, ready_in,
    output req_ready, flit_out, valid_out
  );
endinterface

// File: rtl/noc_local_inject_queue.sv
// Tile-side injection queue: forms dest-tagged flits, drops off-mesh requests and
// feeds a router local port through a first-word fall-through FIFO.
module noc_local_inject_queue #(
  parameter int unsigned ROWS        = 2,
  parameter int unsigned COLS        = 2,
  parameter int unsigned FLIT_W      = 64,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STALL_LIMIT = 64,
  localparam int unsigned OccW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  noc_local_inject_queue_if.slave   bus,
  input  logic                      flush,
  output logic [OccW-1:0]           occ_o,
  output logic [OccW-1:0]           max_occ_o,
  output logic [15:0]               inj_count_o,
  output logic [7:0]                drop_count_o,
  output logic                      drop_pulse_o,
  output logic                      stall_alarm_o
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [OccW-1:0]   occ_q, occ_d, max_q, max_d;
  logic [15:0]       inj_q, inj_d;
  logic [7:0]        drop_q, drop_d;
  logic              pulse_q, pulse_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic              alarm_q, alarm_d;

  logic full, empty, legal, accept, push, pop;

  assign full  = (occ_q == OccW'(DEPTH));
  assign empty = (occ_q == '0);

  assign bus.req_ready = !full && !flush;
  assign bus.valid_out = !empty;
  assign bus.flit_out  = mem_q[rd_q];

  always_comb begin
    legal  = (32'(bus.req_dest_row) < ROWS) && (32'(bus.req_dest_col) < COLS);
    accept = bus.req_valid && bus.req_ready;
    push   = accept && legal;
    pop    = bus.valid_out && bus.ready_in;

    mem_d = mem_q;
    if (push) mem_d[wr_q] = {bus.req_payload, bus.req_dest_row, bus.req_dest_col};

    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop  ? rd_q + 1'b1 : rd_q;

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end

    max_d = (occ_d > max_q) ? occ_d : max_q;

    inj_d   = (pop && inj_q != 16'hFFFF) ? inj_q + 1'b1 : inj_q;
    pulse_d = accept && !legal;
    drop_d  = (pulse_d && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;

    // Counter saturates at the limit; that is all the alarm needs to see.
    if (flush || pop || empty) begin
      stall_d = '0;
    end else if (stall_q != StallW'(STALL_LIMIT)) begin
      stall_d = stall_q + 1'b1;
    end else begin
      stall_d = stall_q;
    end

    // Registered from the current count, so the alarm trails the counter by one cycle.
    alarm_d = (stall_q >= StallW'(STALL_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      max_q   <= '0;
      inj_q   <= '0;
      drop_q  <= '0;
      pulse_q <= 1'b0;
      stall_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      max_q   <= max_d;
      inj_q   <= inj_d;
      drop_q  <= drop_d;
      pulse_q <= pulse_d;
      stall_q <= stall_d;
      alarm_q <= alarm_d;
    end
  end

  assign occ_o         = occ_q;
  assign max_occ_o     = max_q;
  assign inj_count_o   = inj_q;
  assign drop_count_o  = drop_q;
  assign drop_pulse_o  = pulse_q;
  assign stall_alarm_o = alarm_q;
endmodule

// File: tb/tb_noc_local_inject_queue.sv
// Scoreboard bench for noc_local_inject_queue: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_noc_local_inject_queue;
  localparam int unsigned ROWS        = 2;
  localparam int unsigned COLS        = 2;
  localparam int unsigned FLIT_W      = 64;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned STALL_LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  occ, max_occ;
  logic [15:0] inj;
  logic [7:0]  drop;
  logic        pulse, alarm;

  noc_local_inject_queue_if #(.FLIT_W(FLIT_W)) bus ();

  noc_local_inject_queue #(
    .ROWS(ROWS), .COLS(COLS), .FLIT_W(FLIT_W), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .flush         (flush),
    .occ_o         (occ),
    .max_occ_o     (max_occ),
    .inj_count_o   (inj),
    .drop_count_o  (drop),
    .drop_pulse_o  (pulse),
    .stall_alarm_o (alarm)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a list of queued flits plus plain counters.
  logic [63:0] sb[$];
  int m_occ = 0, m_max = 0, m_inj = 0, m_drop = 0, m_stall = 0;
  bit m_pulse = 0, m_alarm = 0;

  always @(posedge clk) begin
    bit v, rdy, pop, acc, legal;
    if (rst) begin
      m_occ = 0; m_max = 0; m_inj = 0; m_drop = 0; m_stall = 0;
      m_pulse = 0; m_alarm = 0;
      sb.delete();
    end else begin
      v     = (m_occ != 0);
      rdy   = (m_occ < int'(DEPTH)) && !flush;
      pop   = v && bus.ready_in;
      acc   = bus.req_valid && rdy;
      legal = (int'(bus.req_dest_row) < int'(ROWS)) && (int'(bus.req_dest_col) < int'(COLS));
      m_alarm = (m_stall >= int'(STALL_LIMIT));
      if (flush || !v || pop) m_stall = 0;
      else if (m_stall < int'(STALL_LIMIT)) m_stall++;
      if (pop) begin
        m_occ--;
        if (m_inj < 16'hFFFF) m_inj++;
      end
      m_pulse = acc && !legal;
      if (m_pulse && m_drop < 8'hFF) m_drop++;
      if (acc && legal) begin
        m_occ++;
        sb.push_back({bus.req_payload, bus.req_dest_row, bus.req_dest_col});
      end
      if (flush) begin
        m_occ = 0;
        sb.delete();
      end
      if (m_occ > m_max) m_max = m_occ;
    end
  end

  // Status checker.
  always @(negedge clk) begin
    check("req_ready", 64'(bus.req_ready), 64'((m_occ < int'(DEPTH)) && !flush));
    check("valid_out", 64'(bus.valid_out), 64'(m_occ != 0));
    check("occ_o", 64'(occ), 64'(m_occ));
    check("max_occ_o", 64'(max_occ), 64'(m_max));
    check("inj_count_o", 64'(inj), 64'(m_inj));
    check("drop_count_o", 64'(drop), 64'(m_drop));
    check("drop_pulse_o", 64'(pulse), 64'(m_pulse));
    check("stall_alarm_o", 64'(alarm), 64'(m_alarm));
  end

  // Flit monitor: compares the presented head and retires it on handshake.
  always @(negedge clk) begin
    if (bus.valid_out) begin
      if (sb.size() == 0) begin
        check("flit_out_unexpected", 64'(bus.valid_out), 64'(0));
      end else begin
        check("flit_out", bus.flit_out, sb[0]);
        if (bus.ready_in) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input int row, input int col, input logic [47:0] pay,
                       input bit rdy, input bit fl, input bit r);
    bus.req_valid    = v;
    bus.req_dest_row = 8'(row);
    bus.req_dest_col = 8'(col);
    bus.req_payload  = pay;
    bus.ready_in     = rdy;
    flush            = fl;
    rst              = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rpay();
    return 48'({$urandom(), $urandom()});
  endfunction

  initial begin
    int hold;
    bit rdy;
    bus.req_valid = 1'b0; bus.req_dest_row = '0; bus.req_dest_col = '0;
    bus.req_payload = '0; bus.ready_in = 1'b0; flush = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 1);

    // Single flit to (1,0).
    drive(1, 1, 0, 48'hABCD, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0, 0);

    // Fill past full while blocked, then drain.
    for (int i = 0; i < 5; i++) drive(1, i % 2, 1, rpay(), 0, 0, 0);
    repeat (6) drive(0, 0, 0, 0, 1, 0, 0);

    // Off-mesh destination.
    drive(1, 2, 0, rpay(), 1, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 2, rpay(), 0, 0, 0);

    // Long stall with one flit queued.
    drive(1, 0, 1, rpay(), 0, 0, 0);
    repeat (70) drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0, 0);

    // Full FIFO streaming with requests held.
    repeat (4) drive(1, 1, 1, rpay(), 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(1, i % 2, (i / 2) % 2, rpay(), 1, 0, 0);
    repeat (6) drive(0, 0, 0, 0, 1, 0, 0);

    // Flush with three queued, then reset with three queued.
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) drive(1, 1, 0, rpay(), 0, 0, 0);
    drive(1, 0, 0, rpay(), 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 1, rpay(), 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    repeat (2) drive(0, 0, 0, 0, 1, 0, 0);

    // Random traffic with occasional long backpressure, flushes and resets.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold > 0) begin
        hold--;
        rdy = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 299) == 0) hold = 80;
      end
      drive($urandom_range(0, 99) < 60,
            ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), rpay(), rdy,
            $urandom_range(0, 99) < 2, $urandom_range(0, 399) == 0);
    end
    repeat (10) drive(0, 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
